fpu_issue_ctrl: RTL and testbench

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

---
 rtl/fpu_issue_ctrl_if.sv | 41 ++++
 rtl/fpu_issue_ctrl.sv | 142 ++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_ctrl_if.sv
// Request, FPU launch/result and response signals of the FPU issue controller.
// slave = controller view, master = requester/FPU environment view.
interface fpu_issue_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_format;
  logic [1:0]  req_operation;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] req_c;

  logic [1:0]  fpu_format;
  logic [1:0]  fpu_operation;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [31:0] fpu_c;
  logic        fpu_start;
  logic [31:0] fpu_output;
  logic [3:0]  fpu_flags;
  logic        fpu_ready;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_error;

  modport slave (
    input  req_valid, req_format, req_operation, req_a, req_b, req_c,
    input  fpu_output, fpu_flags, fpu_ready, rsp_ready,
    output req_ready, fpu_format, fpu_operation, fpu_a, fpu_b, fpu_c, fpu_start,
    output rsp_valid, rsp_result, rsp_flags, rsp_error
  );

  modport master (
    output req_valid, req_format, req_operation, req_a, req_b, req_c,
    output fpu_output, fpu_flags, fpu_ready, rsp_ready,
    input  req_ready, fpu_format, fpu_operation, fpu_a, fpu_b, fpu_c, fpu_start,
    input  rsp_valid, rsp_result, rsp_flags, rsp_error
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issues one FPU operation at a time, waits for the result (with timeout) and returns a response.
// Latency: accept->rsp_valid 3 cycles minimum; illegal format responds 1 cycle after accept.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
module fpu_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  fpu_issue_ctrl_if.slave bus,
  input  logic       clr_sticky,
  output logic [3:0] sticky_flags,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [1:0]  fmt;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } op_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  op_t         op_q;
  logic [7:0]  wait_cnt;
  logic [31:0] rsp_result_q;
  logic [3:0]  rsp_flags_q;
  logic        rsp_error_q;
  logic [3:0]  sticky_q;

  logic        accept;
  logic        illegal;
  logic        capture;
  logic        timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    illegal   = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept    = 1'b1;
          illegal   = (bus.req_format == 2'b11);
          state_nxt = illegal ? RESP : ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // A result arriving on the final wait cycle wins over the timeout.
        if (bus.fpu_ready) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else if (wait_cnt == TMO_LAST) begin
          timeout   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
    end else if (accept) begin
      op_q <= {bus.req_format, bus.req_operation, bus.req_a, bus.req_b, bus.req_c};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
    end else if (state == ISSUE) begin
      wait_cnt <= 8'd0;
    end else if ((state == WAIT) && !bus.fpu_ready) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_q <= 32'd0;
      rsp_flags_q  <= 4'd0;
      rsp_error_q  <= 1'b0;
    end else if (capture) begin
      rsp_result_q <= bus.fpu_output;
      rsp_flags_q  <= bus.fpu_flags;
      rsp_error_q  <= 1'b0;
    end else if (timeout || (accept && illegal)) begin
      rsp_result_q <= 32'd0;
      rsp_flags_q  <= 4'd0;
      rsp_error_q  <= 1'b1;
    end
  end

  // Clear and capture in the same cycle restarts accumulation from the new flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 4'd0;
    end else if (capture) begin
      sticky_q <= clr_sticky ? bus.fpu_flags : (sticky_q | bus.fpu_flags);
    end else if (clr_sticky) begin
      sticky_q <= 4'd0;
    end
  end

  assign bus.req_ready     = (state == IDLE);
  assign bus.fpu_start     = (state == ISSUE);
  assign bus.fpu_format    = op_q.fmt;
  assign bus.fpu_operation = op_q.op;
  assign bus.fpu_a         = op_q.a;
  assign bus.fpu_b         = op_q.b;
  assign bus.fpu_c         = op_q.c;
  assign bus.rsp_valid     = (state == RESP);
  assign bus.rsp_result    = rsp_result_q;
  assign bus.rsp_flags     = rsp_flags_q;
  assign bus.rsp_error     = rsp_error_q;
  assign sticky_flags      = sticky_q;
  assign busy              = (state != IDLE);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: vector table with a response scoreboard, plus a reset-in-WAIT sequence.
module tb_fpu_issue_ctrl;
  localparam int T = 8;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  flags;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [1:0]  fmt;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] out;
    logic [3:0]  flg;
    int          rdy_after;
    bit          clr;
    int          hold;
    bit          exp_err;
    int          exp_wait;
    logic [3:0]  exp_sticky;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       clr_sticky;
  logic [3:0] sticky_flags;
  logic       busy;

  fpu_issue_ctrl_if bus ();

  fpu_issue_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .clr_sticky   (clr_sticky),
    .sticky_flags (sticky_flags),
    .busy         (busy)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   start_cnt = 0;
  rsp_t sb[$];
  vec_t vecs[9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.fpu_start === 1'b1) start_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string nm);
    chk({nm, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({nm, ".busy"}, 32'(busy), 32'd0);
    chk({nm, ".fpu_start"}, 32'(bus.fpu_start), 32'd0);
    chk({nm, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({nm, ".rsp_payload"}, {bus.rsp_result[26:0], bus.rsp_flags, bus.rsp_error}, 32'd0);
    chk({nm, ".rsp_result"}, bus.rsp_result, 32'd0);
    chk({nm, ".sticky"}, 32'(sticky_flags), 32'd0);
    chk({nm, ".fpu_sel"}, {28'd0, bus.fpu_format, bus.fpu_operation}, 32'd0);
    chk({nm, ".fpu_abc"}, bus.fpu_a | bus.fpu_b | bus.fpu_c, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    rsp_t e;
    rsp_t got;
    int   s0;
    int   wc;
    bit   done;
    bit   opnd_ok;
    bit   stab;
    bit   legal;
    legal    = (v.fmt != 2'b11);
    e.result = v.exp_err ? 32'd0 : v.out;
    e.flags  = v.exp_err ? 4'd0 : v.flg;
    e.err    = v.exp_err;

    @(negedge clk);
    chk({nm, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid     = 1'b1;
    bus.req_format    = v.fmt;
    bus.req_operation = v.op;
    bus.req_a         = v.a;
    bus.req_b         = v.b;
    bus.req_c         = v.c;
    clr_sticky        = v.clr;
    s0                = start_cnt;
    sb.push_back(e);

    @(negedge clk);
    bus.req_valid     = 1'b0;
    bus.req_format    = ~v.fmt;
    bus.req_operation = ~v.op;
    bus.req_a         = ~v.a;
    bus.req_b         = ~v.b;
    bus.req_c         = ~v.c;
    chk({nm, ".fpu_start"}, 32'(bus.fpu_start), 32'(legal));
    opnd_ok = (bus.fpu_a == v.a) && (bus.fpu_b == v.b) && (bus.fpu_c == v.c) &&
              (bus.fpu_format == v.fmt) && (bus.fpu_operation == v.op);
    // ready/garbage during ISSUE must be ignored
    bus.fpu_ready  = 1'b1;
    bus.fpu_output = 32'hDEADBEEF;
    bus.fpu_flags  = 4'hF;
    wc   = 0;
    done = bus.rsp_valid;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        done = 1'b1;
      end else begin
        if (bus.fpu_a != v.a || bus.fpu_b != v.b || bus.fpu_c != v.c ||
            bus.fpu_format != v.fmt || bus.fpu_operation != v.op || bus.fpu_start) opnd_ok = 1'b0;
        bus.fpu_ready  = (wc == v.rdy_after);
        bus.fpu_output = v.out;
        bus.fpu_flags  = v.flg;
        wc++;
      end
    end
    clr_sticky = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.rsp_timeout: rsp_valid not seen within 300 cycles", nm);
    end
    chk({nm, ".wait_cycles"}, 32'(wc), 32'(v.exp_wait));
    chk({nm, ".operands"}, 32'(opnd_ok), 32'd1);

    // RESP: garbage on fpu inputs and a competing request must not disturb anything
    bus.fpu_ready  = 1'b1;
    bus.fpu_output = 32'hDEADBEEF;
    bus.fpu_flags  = 4'hF;
    bus.req_valid  = (v.hold > 0);
    stab = 1'b1;
    repeat (v.hold) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
          {bus.rsp_result, bus.rsp_flags, bus.rsp_error} !== e) stab = 1'b0;
    end
    chk({nm, ".hold_stable"}, 32'(stab), 32'd1);
    chk({nm, ".starts"}, 32'(start_cnt - s0), 32'(legal));
    chk({nm, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({nm, ".req_ready_in_resp"}, 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b0;
    bus.fpu_ready = 1'b0;

    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.scoreboard: empty queue with rsp_valid high", nm);
    end else begin
      e   = sb.pop_front();
      got = {bus.rsp_result, bus.rsp_flags, bus.rsp_error};
      chk({nm, ".rsp_result"}, got.result, e.result);
      chk({nm, ".rsp_flags"}, 32'(got.flags), 32'(e.flags));
      chk({nm, ".rsp_error"}, 32'(got.err), 32'(e.err));
    end
    chk({nm, ".sticky_in_resp"}, 32'(sticky_flags), 32'(v.exp_sticky));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({nm, ".idle_after"}, {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);
    chk({nm, ".sticky"}, 32'(sticky_flags), 32'(v.exp_sticky));
  endtask

  initial begin
    int  s0;
    bit  seen;

    vecs[0] = '{2'b00, 2'b00, 32'h3F800000, 32'h40000000, 32'h0, 32'h40400000, 4'b0000, 2, 1'b0, 0, 1'b0, 3, 4'b0000};
    vecs[1] = '{2'b11, 2'b10, 32'h11111111, 32'h22222222, 32'h3, 32'h55555555, 4'b1111, 0, 1'b0, 1, 1'b1, 0, 4'b0000};
    vecs[2] = '{2'b01, 2'b10, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0, 32'h12345678, 4'b0001, 0, 1'b0, 0, 1'b0, 1, 4'b0001};
    vecs[3] = '{2'b10, 2'b11, 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h87654321, 4'b0100, 3, 1'b0, 2, 1'b0, 4, 4'b0101};
    vecs[4] = '{2'b00, 2'b01, 32'hCAFEF00D, 32'h0BADBEEF, 32'h0, 32'h77777777, 4'b1000, 99, 1'b0, 0, 1'b1, T, 4'b0101};
    vecs[5] = '{2'b00, 2'b10, 32'h3F000000, 32'h3F000000, 32'h0, 32'h3E800000, 4'b0010, T - 1, 1'b0, 0, 1'b0, T, 4'b0111};
    vecs[6] = '{2'b11, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 0, 1'b1, 0, 1'b1, 0, 4'b0000};
    vecs[7] = '{2'b01, 2'b11, 32'h00000010, 32'h00000020, 32'h00000030, 32'h00000230, 4'b1000, 1, 1'b1, 0, 1'b0, 2, 4'b1000};
    vecs[8] = '{2'b01, 2'b00, 32'hFFFF0000, 32'h0000FFFF, 32'h0, 32'hFFFFFFFF, 4'b0000, 1, 1'b0, 10, 1'b0, 2, 4'b1000};

    rst_n             = 1'b0;
    clr_sticky        = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_format    = 2'b00;
    bus.req_operation = 2'b00;
    bus.req_a         = 32'd0;
    bus.req_b         = 32'd0;
    bus.req_c         = 32'd0;
    bus.fpu_output    = 32'd0;
    bus.fpu_flags     = 4'd0;
    bus.fpu_ready     = 1'b0;
    bus.rsp_ready     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst_init");
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of WAIT: everything returns to reset values and nothing is emitted later.
    @(negedge clk);
    bus.req_valid     = 1'b1;
    bus.req_format    = 2'b00;
    bus.req_operation = 2'b10;
    bus.req_a         = 32'h40800000;
    bus.req_b         = 32'h40A00000;
    bus.req_c         = 32'h1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.fpu_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wait.busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset("rst_wait");
    @(negedge clk);
    rst_n = 1'b1;
    s0    = start_cnt;
    seen  = 1'b0;
    bus.fpu_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
    end
    bus.fpu_ready = 1'b0;
    chk("rst_wait.no_rsp_after", 32'(seen), 32'd0);
    chk("rst_wait.no_start_after", 32'(start_cnt - s0), 32'd0);
    chk("rst_wait.idle", {30'd0, busy, bus.req_ready}, 32'd1);
    chk("scoreboard.empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
